// File: rtl/wb_sram_ctrl_pkg.sv
// wb_sram_ctrl_pkg: shared widths, FSM state encoding and state-class helpers
package wb_sram_ctrl_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_RMW_RD   = 3'd2,
        S_WR_SETUP = 3'd3,
        S_WR_PULSE = 3'd4,
        S_WR_HOLD  = 3'd5,
        S_ACK      = 3'd6
    } sram_state_e;

    function automatic logic is_rd(input sram_state_e s);
        return s == S_RD || s == S_RMW_RD;
    endfunction

    function automatic logic is_wr(input sram_state_e s);
        return s == S_WR_SETUP || s == S_WR_PULSE || s == S_WR_HOLD;
    endfunction

endpackage

// File: rtl/wb_sram_ctrl_merge.sv
// wb_sram_ctrl_merge: byte-wise merge of the old SRAM word with new write data
module wb_sram_ctrl_merge
    import wb_sram_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] new_word,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] merged
);

    for (genvar i = 0; i < SEL_W; i++) begin : g_byte
        assign merged[8*i +: 8] = sel[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end

endmodule

// File: rtl/wb_sram_ctrl.sv
// wb_sram_ctrl: Wishbone classic responder driving one asynchronous 1Mx32 SRAM bank
module wb_sram_ctrl
    import wb_sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [SEL_W-1:0]  wb_sel_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_ack_o,
    output logic [ADDR_W-1:0] sram_addr,
    inout  logic [DATA_W-1:0] sram_data,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam logic [7:0] LAST = 8'(WAIT_CYCLES);

    sram_state_e       state, state_nx;
    logic [7:0]        cnt;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] wdata_q, merged;
    logic              abort_q, zero_q, drive_en;
    logic              req, last;

    assign req  = wb_cyc_i & wb_stb_i;
    assign last = cnt == LAST;

    assign sram_data = drive_en ? wdata_q : 'z;

    wb_sram_ctrl_merge u_merge (
        .old_word (sram_data),
        .new_word (wdata_q),
        .sel      (sel_q),
        .merged   (merged)
    );

    // state register and phase counter, restarted on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? '0 : cnt + 8'd1;
        end
    end

    // next state and acknowledge; a sel=0 write spends one silent cycle in ACK
    always_comb begin
        state_nx = state;
        wb_ack_o = 1'b0;
        case (state)
            S_IDLE:     if (req) state_nx = !wb_we_i ? S_RD :
                                            wb_sel_i == 4'hF ? S_WR_SETUP :
                                            wb_sel_i == 4'h0 ? S_ACK : S_RMW_RD;
            S_RD:       if (last) state_nx = S_ACK;
            S_RMW_RD:   if (last) state_nx = S_WR_SETUP;
            S_WR_SETUP: state_nx = S_WR_PULSE;
            S_WR_PULSE: if (last) state_nx = S_WR_HOLD;
            S_WR_HOLD:  state_nx = S_ACK;
            S_ACK: begin
                state_nx = zero_q ? S_ACK : S_IDLE;
                wb_ack_o = req & ~abort_q & ~zero_q;
            end
            default:    state_nx = S_IDLE;
        endcase
    end

    // SRAM strobes and data enable registered from the next state so they never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            drive_en  <= 1'b0;
        end else begin
            sram_ce_n <= ~(is_rd(state_nx) | is_wr(state_nx));
            sram_oe_n <= ~is_rd(state_nx);
            sram_we_n <= state_nx != S_WR_PULSE;
            drive_en  <= is_wr(state_nx);
        end
    end

    // request latching, read capture, read-modify-write merge and abort tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_addr <= '0;
            sel_q     <= '0;
            wdata_q   <= '0;
            wb_data_o <= '0;
            abort_q   <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            if (state == S_IDLE && req) begin
                sram_addr <= wb_addr_i;
                sel_q     <= wb_sel_i;
                wdata_q   <= wb_data_i;
            end
            if (state == S_RD && last)
                wb_data_o <= sram_data;
            if (state == S_RMW_RD && last)
                wdata_q <= merged;
            abort_q <= (state != S_IDLE) & (abort_q | ~req);
            zero_q  <= (state == S_IDLE) ? req & wb_we_i & (wb_sel_i == 4'h0) : 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// tb_wb_sram_ctrl: directed and randomized checks of wb_sram_ctrl against an SRAM and memory model
module tb_wb_sram_ctrl;
    import wb_sram_ctrl_pkg::*;

    localparam int W = 1;

    logic        clk, rst_n;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [19:0] wb_addr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_data_i, wb_data_o;
    logic        wb_ack_o;
    logic [19:0] sram_addr;
    wire  [31:0] sram_data;
    logic        sram_ce_n, sram_oe_n, sram_we_n;

    int compared = 0;
    int errs = 0;

    logic [31:0] mem [0:(1<<20)-1];
    logic [31:0] model [int];

    wb_sram_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_addr_i(wb_addr_i), .wb_sel_i(wb_sel_i), .wb_data_i(wb_data_i),
        .wb_data_o(wb_data_o), .wb_ack_o(wb_ack_o),
        .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 'z;

    always @(posedge clk)
        if (rst_n && !sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_data;

    int          ack_cnt = 0, rd_acc = 0, ce_low = 0, we_run = 0, run = 0;
    logic        we_prev = 1, p_oe = 1, p_ce = 1, setup_ok = 0, hold_ok = 0;
    logic [19:0] p_addr, pulse_addr;
    logic [31:0] p_data, pulse_data;

    always @(negedge clk) begin
        if (rst_n) begin
            compared++;
            assert (!(!sram_oe_n && !sram_we_n)) else begin
                errs++; $error("FAIL oe_we_overlap: oe_n=%b we_n=%b required not both 0", sram_oe_n, sram_we_n);
            end
            compared++;
            assert (!(dut.drive_en && !sram_oe_n)) else begin
                errs++; $error("FAIL drive_while_oe: drive_en=%b oe_n=%b required no drive", dut.drive_en, sram_oe_n);
            end
        end
        if (!sram_we_n) begin
            if (we_prev) begin
                run = 0;
                pulse_addr = sram_addr;
                pulse_data = sram_data;
                setup_ok = p_addr == sram_addr && p_data == sram_data && !p_ce;
            end
            run++;
            if (sram_addr != pulse_addr || sram_data != pulse_data) setup_ok = 0;
        end else if (!we_prev) begin
            we_run = run;
            hold_ok = setup_ok && sram_addr == pulse_addr && sram_data == pulse_data && !sram_ce_n;
        end
        if (!sram_oe_n && p_oe) rd_acc++;
        if (!sram_ce_n) ce_low++;
        if (wb_ack_o) ack_cnt++;
        p_addr = sram_addr; p_data = sram_data; p_ce = sram_ce_n; p_oe = sram_oe_n; we_prev = sram_we_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            errs++; $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input int a);
        return model.exists(a) ? model[a] : 32'h0;
    endfunction

    function automatic logic [31:0] mask_of(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
        return m;
    endfunction

    function automatic int exp_lat(input logic we, input logic [3:0] s);
        if (!we) return W + 1;
        if (s == 4'hF) return W + 3;
        if (s == 4'h0) return 1;
        return 2 * W + 4;
    endfunction

    task automatic xfer(input logic we, input logic [19:0] a, input logic [3:0] s, input logic [31:0] d,
                        output int lat, output logic [31:0] rd);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_addr_i = a; wb_sel_i = s; wb_data_i = d;
        lat = -1; rd = 'x;
        if (we) model[int'(a)] = (model_rd(int'(a)) & ~mask_of(s)) | (d & mask_of(s));
        @(posedge clk);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (wb_ack_o) begin lat = n; rd = wb_data_o; break; end
            @(posedge clk);
        end
        @(posedge clk); #1;
        wb_cyc_i = 0; wb_stb_i = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, a0, c0;
        logic [31:0] rd, d;
        logic [19:0] a;
        logic [3:0]  s;
        logic        we;
        for (int i = 0; i < (1 << 20); i++) mem[i] = 32'h0;
        rst_n = 0; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_addr_i = 0; wb_sel_i = 0; wb_data_i = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_data_o", wb_data_o, 32'd0);
        check("rst_drive", 32'(dut.drive_en), 32'd0);
        rst_n = 1;
        @(posedge clk); #1;

        a0 = ack_cnt;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_addr_i = 20'h00010; wb_sel_i = 4'hF; wb_data_i = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("rstpulse_we_low", 32'(sram_we_n), 32'd0);
        rst_n = 0;
        #1;
        check("rstpulse_we_n", 32'(sram_we_n), 32'd1);
        check("rstpulse_ce_n", 32'(sram_ce_n), 32'd1);
        check("rstpulse_drive", 32'(dut.drive_en), 32'd0);
        check("rstpulse_state", 32'(dut.state), 32'(S_IDLE));
        wb_cyc_i = 0; wb_stb_i = 0;
        @(posedge clk); #1;
        rst_n = 1;
        repeat (6) @(posedge clk);
        #1;
        check("rstpulse_no_ack", 32'(ack_cnt - a0), 32'd0);
        model[32'h10] = mem[20'h00010];

        we_run = 0;
        xfer(1, 20'h00010, 4'hF, 32'hDEADBEEF, lat, rd);
        check("full_wr_lat", 32'(lat), 32'(exp_lat(1, 4'hF)));
        check("full_wr_we_run", 32'(we_run), 32'(W + 1));
        check("full_wr_setup_hold", {30'd0, setup_ok, hold_ok}, 32'd3);
        check("full_wr_pulse_data", pulse_data, 32'hDEADBEEF);
        check("full_wr_mem", mem[20'h00010], 32'hDEADBEEF);
        xfer(0, 20'h00010, 4'h3, 32'h0, lat, rd);
        check("rd_lat", 32'(lat), 32'(exp_lat(0, 4'h0)));
        check("rd_data", rd, 32'hDEADBEEF);

        mem[20'hFFFFF] = 32'h11223344;
        model[32'hFFFFF] = 32'h11223344;
        xfer(1, 20'hFFFFF, 4'b0101, 32'hAABBCCDD, lat, rd);
        check("rmw_lat", 32'(lat), 32'(exp_lat(1, 4'b0101)));
        check("rmw_mem", mem[20'hFFFFF], 32'h11BB33DD);
        check("rmw_model", mem[20'hFFFFF], model_rd(32'hFFFFF));
        check("rmw_pulse_data", pulse_data, 32'h11BB33DD);

        c0 = ce_low;
        xfer(1, 20'h00010, 4'h0, 32'h12345678, lat, rd);
        check("sel0_lat", 32'(lat), 32'(exp_lat(1, 4'h0)));
        check("sel0_no_ce", 32'(ce_low - c0), 32'd0);
        check("sel0_mem", mem[20'h00010], 32'hDEADBEEF);

        a0 = ack_cnt; we_run = 0;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_addr_i = 20'h00020; wb_sel_i = 4'hF; wb_data_i = 32'h5A5AA5A5;
        model[32'h20] = 32'h5A5AA5A5;
        @(posedge clk);
        @(posedge clk); #1;
        wb_cyc_i = 0;
        repeat (8) @(posedge clk);
        #1; wb_stb_i = 0;
        check("abort_no_ack", 32'(ack_cnt - a0), 32'd0);
        check("abort_we_run", 32'(we_run), 32'(W + 1));
        check("abort_mem", mem[20'h00020], 32'h5A5AA5A5);
        xfer(0, 20'h00020, 4'hF, 32'h0, lat, rd);
        check("abort_next_lat", 32'(lat), 32'(exp_lat(0, 4'h0)));
        check("abort_next_data", rd, 32'h5A5AA5A5);

        for (int i = 0; i < 3; i++) begin
            mem[i] = 32'h0BAD0000 + 32'(i);
            model[i] = 32'h0BAD0000 + 32'(i);
        end
        a0 = ack_cnt; c0 = rd_acc;
        for (int i = 0; i < 3; i++) begin
            xfer(0, 20'(i), 4'hF, 32'h0, lat, rd);
            check("b2b_lat", 32'(lat), 32'(exp_lat(0, 4'h0)));
            check("b2b_data", rd, model_rd(i));
        end
        @(negedge clk);
        check("b2b_ack_count", 32'(ack_cnt - a0), 32'd3);
        check("b2b_access_count", 32'(rd_acc - c0), 32'd3);

        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = 20'($urandom_range(0, 7));
            s  = 4'($urandom_range(0, 15));
            d  = $urandom;
            xfer(we, a, s, d, lat, rd);
            check(we ? "rnd_wr_lat" : "rnd_rd_lat", 32'(lat), 32'(exp_lat(we, s)));
            if (we) check("rnd_wr_mem", mem[a], model_rd(int'(a)));
            else    check("rnd_rd_data", rd, model_rd(int'(a)));
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errs);
        $finish;
    end

endmodule
